// File: rtl/accelbrot_pkg.sv
// Shared constants and types for the accelbrot command sequencer.
// Engine command codes, scan flag bit positions and the scheduler state set.
package accelbrot_pkg;

    localparam logic [7:0] CMD_EDGE_SCAN = 8'h01;
    localparam logic [7:0] CMD_RECT_SCAN = 8'h02;

    localparam int SCAN_FLAG_WRITE     = 0;
    localparam int SCAN_FLAG_PUSH_TASK = 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        ACK,
        RUN,
        NEXT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/accelbrot_tile_iter.sv
// Raster walker over the image: holds the current tile origin,
// clips the tile to the image edge and flags the final tile.
module accelbrot_tile_iter #(
    parameter int PWIDTH = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              init_i,
    input  logic              step_i,
    input  logic [PWIDTH-1:0] img_w_i,
    input  logic [PWIDTH-1:0] img_h_i,
    input  logic [PWIDTH-1:0] tile_w_i,
    input  logic [PWIDTH-1:0] tile_h_i,
    output logic [PWIDTH-1:0] rect_x_o,
    output logic [PWIDTH-1:0] rect_y_o,
    output logic [PWIDTH-1:0] rect_w_o,
    output logic [PWIDTH-1:0] rect_h_o,
    output logic              last_o
);

    logic [PWIDTH-1:0] x_q, x_d;
    logic [PWIDTH-1:0] y_q, y_d;
    logic [PWIDTH:0]   nx;
    logic [PWIDTH:0]   ny;
    logic [PWIDTH-1:0] rem_w;
    logic [PWIDTH-1:0] rem_h;
    logic              x_wrap;
    logic              y_wrap;

    // Next origin in one extra bit so x+tw cannot wrap; clip to remaining image.
    always_comb begin
        nx     = {1'b0, x_q} + {1'b0, tile_w_i};
        ny     = {1'b0, y_q} + {1'b0, tile_h_i};
        x_wrap = (nx >= {1'b0, img_w_i});
        y_wrap = (ny >= {1'b0, img_h_i});
        rem_w  = img_w_i - x_q;
        rem_h  = img_h_i - y_q;
        rect_x_o = x_q;
        rect_y_o = y_q;
        rect_w_o = (tile_w_i < rem_w) ? tile_w_i : rem_w;
        rect_h_o = (tile_h_i < rem_h) ? tile_h_i : rem_h;
        last_o   = x_wrap && y_wrap;
        x_d = x_q;
        y_d = y_q;
        if (init_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = ny[PWIDTH-1:0];
            end else begin
                x_d = nx[PWIDTH-1:0];
            end
        end
    end

    // Origin registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/accelbrot_tile_sched.sv
// Frame sequencer: issues one RECT_SCAN per tile and an optional final
// EDGE_SCAN, handshaking each command against the engine busy status.
module accelbrot_tile_sched #(
    parameter int PWIDTH      = 12,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PWIDTH-1:0]     cfg_img_width,
    input  logic [PWIDTH-1:0]     cfg_img_height,
    input  logic [PWIDTH-1:0]     cfg_tile_w,
    input  logic [PWIDTH-1:0]     cfg_tile_h,
    input  logic [31:0]           cfg_rect_value,
    input  logic [31:0]           cfg_rect_flags,
    input  logic                  cfg_edge_en,
    output logic [7:0]            cmd_command,
    output logic [PWIDTH-1:0]     cmd_rect_x,
    output logic [PWIDTH-1:0]     cmd_rect_y,
    output logic [PWIDTH-1:0]     cmd_rect_width,
    output logic [PWIDTH-1:0]     cmd_rect_height,
    output logic [31:0]           cmd_rect_value,
    output logic [31:0]           cmd_flags,
    output logic                  cmd_valid,
    input  logic                  eng_busy,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_error,
    output logic                  sts_aborted,
    output logic [2*PWIDTH-1:0]   sts_tile_count
);

    import accelbrot_pkg::*;

    localparam int TW = $clog2(ACK_TIMEOUT);
    // ISSUE and the final ACK cycle complete the ACK_TIMEOUT window.
    localparam logic [TW-1:0] TO_LOAD = TW'(ACK_TIMEOUT - 2);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [2*PWIDTH-1:0] CNT_ONE = (2*PWIDTH)'(1);

    sched_state_t        state_q;
    logic [PWIDTH-1:0]   w_q;
    logic [PWIDTH-1:0]   h_q;
    logic [PWIDTH-1:0]   tw_q;
    logic [PWIDTH-1:0]   th_q;
    logic [31:0]         value_q;
    logic [31:0]         flags_q;
    logic                edge_en_q;
    logic                edge_q;
    logic                abort_q;
    logic [TW-1:0]       tmo_q;
    logic                cmd_valid_q;
    logic [7:0]          cmd_command_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                aborted_q;
    logic [2*PWIDTH-1:0] count_q;

    logic              abort_hit;
    logic              it_init;
    logic              it_step;
    logic              it_last;
    logic [PWIDTH-1:0] it_x;
    logic [PWIDTH-1:0] it_y;
    logic [PWIDTH-1:0] it_w;
    logic [PWIDTH-1:0] it_h;

    assign abort_hit = abort_q | abort;
    assign it_init   = (state_q == INIT);
    assign it_step   = (state_q == NEXT) && !abort_hit && !it_last;

    accelbrot_tile_iter #(
        .PWIDTH (PWIDTH)
    ) u_iter (
        .clk      (clk),
        .rstn     (rstn),
        .init_i   (it_init),
        .step_i   (it_step),
        .img_w_i  (w_q),
        .img_h_i  (h_q),
        .tile_w_i (tw_q),
        .tile_h_i (th_q),
        .rect_x_o (it_x),
        .rect_y_o (it_y),
        .rect_w_o (it_w),
        .rect_h_o (it_h),
        .last_o   (it_last)
    );

    // Command fields: current tile, or the whole image for the edge pass.
    always_comb begin
        cmd_rect_x      = edge_q ? '0  : it_x;
        cmd_rect_y      = edge_q ? '0  : it_y;
        cmd_rect_width  = edge_q ? w_q : it_w;
        cmd_rect_height = edge_q ? h_q : it_h;
        cmd_flags       = edge_q ? '0  : flags_q;
    end

    assign cmd_rect_value = value_q;
    assign cmd_command    = cmd_command_q;
    assign cmd_valid      = cmd_valid_q;
    assign sts_busy       = busy_q;
    assign sts_done       = done_q;
    assign sts_error      = error_q;
    assign sts_aborted    = aborted_q;
    assign sts_tile_count = count_q;

    // Sequencer FSM with registered strobes and status.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            w_q           <= '0;
            h_q           <= '0;
            tw_q          <= '0;
            th_q          <= '0;
            value_q       <= '0;
            flags_q       <= '0;
            edge_en_q     <= 1'b0;
            edge_q        <= 1'b0;
            abort_q       <= 1'b0;
            tmo_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_command_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            aborted_q     <= 1'b0;
            count_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= abort_q | abort;
            unique case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    w_q       <= cfg_img_width;
                    h_q       <= cfg_img_height;
                    tw_q      <= (cfg_tile_w == '0) ? cfg_img_width : cfg_tile_w;
                    th_q      <= (cfg_tile_h == '0) ? cfg_img_height : cfg_tile_h;
                    value_q   <= cfg_rect_value;
                    flags_q   <= cfg_rect_flags;
                    edge_en_q <= cfg_edge_en;
                    edge_q    <= 1'b0;
                    error_q   <= 1'b0;
                    aborted_q <= 1'b0;
                    count_q   <= '0;
                    if (abort) begin
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (cfg_img_width == '0 || cfg_img_height == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cmd_valid_q   <= 1'b1;
                        cmd_command_q <= CMD_RECT_SCAN;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_q   <= TO_LOAD;
                    state_q <= ACK;
                end
                ACK: begin
                    if (eng_busy) begin
                        state_q <= RUN;
                    end else if (tmo_q == '0) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q - TO_ONE;
                    end
                end
                RUN: begin
                    if (!eng_busy) begin
                        if (!edge_q) begin
                            count_q <= count_q + CNT_ONE;
                        end
                        if (abort_hit) begin
                            aborted_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else if (edge_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (abort_hit) begin
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (!it_last) begin
                        cmd_valid_q   <= 1'b1;
                        cmd_command_q <= CMD_RECT_SCAN;
                        state_q       <= ISSUE;
                    end else if (edge_en_q) begin
                        edge_q        <= 1'b1;
                        cmd_valid_q   <= 1'b1;
                        cmd_command_q <= CMD_EDGE_SCAN;
                        state_q       <= ISSUE;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q        <= 1'b0;
                    abort_q       <= 1'b0;
                    cmd_command_q <= '0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accelbrot_tile_sched.sv
// Directed bench for the tile sequencer with a simple engine model.
// Expected tiles, latencies and status are hand-computed constants.
module tb_accelbrot_tile_sched;
    import accelbrot_pkg::*;

    localparam int PW = 12;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [PW-1:0] cfg_img_width = '0;
    logic [PW-1:0] cfg_img_height = '0;
    logic [PW-1:0] cfg_tile_w = '0;
    logic [PW-1:0] cfg_tile_h = '0;
    logic [31:0] cfg_rect_value = '0;
    logic [31:0] cfg_rect_flags = '0;
    logic cfg_edge_en = 1'b0;
    logic [7:0] cmd_command;
    logic [PW-1:0] cmd_rect_x, cmd_rect_y, cmd_rect_width, cmd_rect_height;
    logic [31:0] cmd_rect_value, cmd_flags;
    logic cmd_valid;
    logic eng_busy = 1'b0;
    logic sts_busy, sts_done, sts_error, sts_aborted;
    logic [2*PW-1:0] sts_tile_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]    cmd;
        logic [PW-1:0] x, y, w, h;
        logic [31:0]   val, flags;
    } rec_t;

    rec_t recs[$];
    int done_cnt = 0;

    int model_en = 1;
    int ack_dly = 3;
    int busy_len = 10;
    int eng_phase = 0;
    int eng_cnt = 0;

    always #5 clk = ~clk;

    accelbrot_tile_sched #(
        .PWIDTH(PW),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .abort(abort),
        .cfg_img_width(cfg_img_width),
        .cfg_img_height(cfg_img_height),
        .cfg_tile_w(cfg_tile_w),
        .cfg_tile_h(cfg_tile_h),
        .cfg_rect_value(cfg_rect_value),
        .cfg_rect_flags(cfg_rect_flags),
        .cfg_edge_en(cfg_edge_en),
        .cmd_command(cmd_command),
        .cmd_rect_x(cmd_rect_x),
        .cmd_rect_y(cmd_rect_y),
        .cmd_rect_width(cmd_rect_width),
        .cmd_rect_height(cmd_rect_height),
        .cmd_rect_value(cmd_rect_value),
        .cmd_flags(cmd_flags),
        .cmd_valid(cmd_valid),
        .eng_busy(eng_busy),
        .sts_busy(sts_busy),
        .sts_done(sts_done),
        .sts_error(sts_error),
        .sts_aborted(sts_aborted),
        .sts_tile_count(sts_tile_count)
    );

    // Command and done monitor.
    always @(negedge clk) begin
        rec_t r;
        if (cmd_valid) begin
            r.cmd = cmd_command;
            r.x = cmd_rect_x;
            r.y = cmd_rect_y;
            r.w = cmd_rect_width;
            r.h = cmd_rect_height;
            r.val = cmd_rect_value;
            r.flags = cmd_flags;
            recs.push_back(r);
        end
        if (sts_done) done_cnt++;
    end

    // Engine model: busy rises ack_dly cycles after a command, lasts busy_len.
    always @(negedge clk) begin
        if (!rstn) begin
            eng_busy = 1'b0;
            eng_phase = 0;
        end else if (eng_phase == 0) begin
            if (cmd_valid && model_en != 0) begin
                eng_cnt = ack_dly;
                eng_phase = 1;
            end
        end else if (eng_phase == 1) begin
            if (eng_cnt <= 1) begin
                eng_busy = 1'b1;
                eng_cnt = busy_len;
                eng_phase = 2;
            end else eng_cnt--;
        end else begin
            if (eng_cnt <= 1) begin
                eng_busy = 1'b0;
                eng_phase = 0;
            end else eng_cnt--;
        end
    end

    task automatic set_cfg(input logic [PW-1:0] w, h, tw, th, input logic e);
        cfg_img_width = w;
        cfg_img_height = h;
        cfg_tile_w = tw;
        cfg_tile_h = th;
        cfg_edge_en = e;
        cfg_rect_value = 32'hCAFE_0001;
        cfg_rect_flags = 32'h0000_0003;
    endtask

    // Returns on the negedge inside the INIT cycle.
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (sts_done) got = 1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_command, cmd_rect_x, cmd_rect_y, cmd_rect_width,
             cmd_rect_height, cmd_rect_value, cmd_flags, cmd_valid,
             sts_busy, sts_done, sts_error, sts_aborted,
             sts_tile_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got nonzero cmd=%h busy=%b cnt=%0d want all 0",
                     cmd_command, sts_busy, sts_tile_count);
        end
    endtask

    task automatic test_raster(input string tag);
        logic [PW-1:0] ex_x[4] = '{12'd0, 12'd64, 12'd0, 12'd64};
        logic [PW-1:0] ex_y[4] = '{12'd0, 12'd0, 12'd32, 12'd32};
        logic [PW-1:0] ex_w[4] = '{12'd64, 12'd36, 12'd64, 12'd36};
        logic [PW-1:0] ex_h[4] = '{12'd32, 12'd32, 12'd18, 12'd18};
        bit got;
        int d0;
        set_cfg(100, 50, 64, 32, 1'b0);
        recs.delete();
        d0 = done_cnt;
        pulse_start();
        checks++;
        if (cmd_valid !== 1'b0 || sts_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s lat_init valid=%b busy=%b want 0/1", tag, cmd_valid, sts_busy);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s lat_issue valid=%b want 1", tag, cmd_valid);
        end
        set_cfg(7, 9, 3, 3, 1'b1);
        cfg_rect_value = 32'h0;
        wait_done(400, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s done_timeout got none want sts_done", tag);
        end
        checks++;
        if (sts_tile_count !== 24'd4 || sts_error !== 1'b0 || sts_aborted !== 1'b0) begin
            failures++;
            $display("FAIL %s status cnt=%0d err=%b ab=%b want 4/0/0",
                     tag, sts_tile_count, sts_error, sts_aborted);
        end
        checks++;
        if (recs.size() != 4) begin
            failures++;
            $display("FAIL %s rect_count got %0d want 4", tag, recs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (recs[i].cmd !== CMD_RECT_SCAN || recs[i].x !== ex_x[i] ||
                    recs[i].y !== ex_y[i] || recs[i].w !== ex_w[i] ||
                    recs[i].h !== ex_h[i] || recs[i].flags !== 32'h3 ||
                    recs[i].val !== 32'hCAFE_0001) begin
                    failures++;
                    $display("FAIL %s rect%0d got c=%h (%0d,%0d,%0d,%0d) f=%h v=%h want (%0d,%0d,%0d,%0d)",
                             tag, i, recs[i].cmd, recs[i].x, recs[i].y, recs[i].w,
                             recs[i].h, recs[i].flags, recs[i].val,
                             ex_x[i], ex_y[i], ex_w[i], ex_h[i]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (sts_busy !== 1'b0 || cmd_command !== 8'h00 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL %s idle_after busy=%b cmd=%h dones=%0d want 0/00/1",
                     tag, sts_busy, cmd_command, done_cnt - d0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_edge;
        bit got;
        int d0;
        set_cfg(100, 50, 64, 32, 1'b1);
        recs.delete();
        d0 = done_cnt;
        pulse_start();
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(500, got);
        checks++;
        if (!got || sts_tile_count !== 24'd4) begin
            failures++;
            $display("FAIL edge_done got=%0d cnt=%0d want 1/4", got, sts_tile_count);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (recs.size() != 5 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL edge_cmds got %0d cmds %0d dones want 5/1",
                     recs.size(), done_cnt - d0);
        end else begin
            checks++;
            if (recs[4].cmd !== CMD_EDGE_SCAN || recs[4].x !== 12'd0 ||
                recs[4].y !== 12'd0 || recs[4].w !== 12'd100 ||
                recs[4].h !== 12'd50 || recs[4].flags !== 32'h0 ||
                recs[4].val !== 32'hCAFE_0001) begin
                failures++;
                $display("FAIL edge_fields got c=%h (%0d,%0d,%0d,%0d) f=%h v=%h want 01 (0,0,100,50) f=0",
                         recs[4].cmd, recs[4].x, recs[4].y, recs[4].w,
                         recs[4].h, recs[4].flags, recs[4].val);
            end
            checks++;
            if (recs[3].cmd !== CMD_RECT_SCAN || recs[3].w !== 12'd36 ||
                recs[3].h !== 12'd18) begin
                failures++;
                $display("FAIL edge_last_rect got c=%h w=%0d h=%0d want 02/36/18",
                         recs[3].cmd, recs[3].w, recs[3].h);
            end
        end
    endtask

    task automatic test_timeout;
        int dk;
        logic err;
        set_cfg(100, 50, 64, 32, 1'b0);
        model_en = 0;
        recs.delete();
        pulse_start();
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL tmo_issue valid=%b want 1", cmd_valid);
        end
        dk = -1;
        err = 1'b0;
        for (int k = 1; k <= 24 && dk < 0; k++) begin
            @(negedge clk);
            if (sts_done) begin
                dk = k;
                err = sts_error;
            end
        end
        checks++;
        if (dk != 16 || err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_latency got done at %0d err=%b want 16/1", dk, err);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (recs.size() != 1 || sts_error !== 1'b1 || sts_tile_count !== 24'd0) begin
            failures++;
            $display("FAIL tmo_after cmds=%0d err=%b cnt=%0d want 1/1/0",
                     recs.size(), sts_error, sts_tile_count);
        end
        model_en = 1;
    endtask

    task automatic test_abort;
        bit seen;
        bit bad;
        bit got;
        set_cfg(100, 50, 64, 32, 1'b0);
        busy_len = 20;
        recs.delete();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (recs.size() == 2 && eng_busy) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_setup got no busy tile 2 want busy");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bad = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (sts_done) got = 1;
            else if (eng_busy && !sts_busy) bad = 1;
        end
        checks++;
        if (!got || bad) begin
            failures++;
            $display("FAIL abort_wait done=%0d early_idle=%0d want 1/0", got, bad);
        end
        checks++;
        if (sts_aborted !== 1'b1 || sts_tile_count !== 24'd2 || sts_error !== 1'b0) begin
            failures++;
            $display("FAIL abort_status ab=%b cnt=%0d err=%b want 1/2/0",
                     sts_aborted, sts_tile_count, sts_error);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (recs.size() != 2) begin
            failures++;
            $display("FAIL abort_cmds got %0d want 2", recs.size());
        end
        busy_len = 10;
    endtask

    task automatic test_empty;
        bit got;
        set_cfg(0, 50, 64, 32, 1'b1);
        recs.delete();
        pulse_start();
        checks++;
        if (sts_done !== 1'b0) begin
            failures++;
            $display("FAIL empty_early done=%b want 0", sts_done);
        end
        @(negedge clk);
        checks++;
        if (sts_done !== 1'b1 || sts_tile_count !== 24'd0) begin
            failures++;
            $display("FAIL empty_done done=%b cnt=%0d want 1/0", sts_done, sts_tile_count);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (recs.size() != 0) begin
            failures++;
            $display("FAIL empty_cmds got %0d want 0", recs.size());
        end
        set_cfg(40, 8, 0, 0, 1'b0);
        pulse_start();
        wait_done(200, got);
        repeat (3) @(negedge clk);
        checks++;
        if (!got || recs.size() != 1 || sts_tile_count !== 24'd1) begin
            failures++;
            $display("FAIL full_tile done=%0d cmds=%0d cnt=%0d want 1/1/1",
                     got, recs.size(), sts_tile_count);
        end else begin
            checks++;
            if (recs[0].x !== 12'd0 || recs[0].y !== 12'd0 ||
                recs[0].w !== 12'd40 || recs[0].h !== 12'd8) begin
                failures++;
                $display("FAIL full_tile_rect got (%0d,%0d,%0d,%0d) want (0,0,40,8)",
                         recs[0].x, recs[0].y, recs[0].w, recs[0].h);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int d0;
        set_cfg(100, 50, 64, 32, 1'b0);
        recs.delete();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (eng_busy) seen = 1;
        end
        d0 = done_cnt;
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {cmd_command, cmd_rect_x, cmd_rect_y, cmd_rect_width,
             cmd_rect_height, cmd_rect_value, cmd_flags, cmd_valid,
             sts_busy, sts_done, sts_error, sts_aborted,
             sts_tile_count} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs seen=%0d busy=%b cnt=%0d cmd=%h want all 0",
                     seen, sts_busy, sts_tile_count, cmd_command);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL midreset_no_done got %0d dones want 0", done_cnt - d0);
        end
        test_raster("after_reset");
    endtask

    initial begin
        test_reset();
        test_raster("raster");
        test_edge();
        test_timeout();
        test_abort();
        test_empty();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
